instr_fetch_unit: RTL
=====================

Name: instr_fetch_unit

Overview:
Multicycle fetch stage directly upstream of the main control FSM. It holds PC, OldPC and the instruction register, and issues word reads to unified memory over a req/ack handshake. It presents the decoded instruction fields, including the opcode consumed by the control FSM. Memory latency is variable; the unit adds a timeout and a misalignment fault.

Parameters:
XLEN, 32, datapath/address width
RESET_PC, 32'h0000_0000, PC value after reset
TIMEOUT, 15, maximum wait cycles for i_mem_ack before fault (1..255)

Ports:
i_clk  input  1  clock, rising edge
i_rst  input  1  reset, synchronous, active-high
i_fetch  input  1  start-fetch pulse from control FSM; ignored unless state IDLE
i_pc_we  input  1  PC write enable (PCUpdate/branch/PC+4)
i_pc_next  input  XLEN  new PC value
i_fault_clr  input  1  clears sticky fault, returns to IDLE
o_mem_req  output  1  memory read request
o_mem_addr  output  XLEN  request address, word aligned
i_mem_ack  input  1  read data valid this cycle
i_mem_rdata  input  32  read data
o_instr  output  32  instruction register
o_instr_valid  output  1  one-cycle pulse: new instruction in o_instr
o_opcode  output  7  o_instr[6:0]
o_rd  output  5  o_instr[11:7]
o_funct3  output  3  o_instr[14:12]
o_rs1  output  5  o_instr[19:15]
o_rs2  output  5  o_instr[24:20]
o_funct7  output  7  o_instr[31:25]
o_pc  output  XLEN  current PC
o_old_pc  output  XLEN  PC of instruction held in o_instr
o_busy  output  1  high in REQ/WAIT
o_fault  output  1  sticky fault flag
o_fault_cause  output  2  01 misaligned, 10 timeout, 00 none

Behaviour:
- Reset (i_rst high at clock edge): state IDLE, o_pc=o_old_pc=RESET_PC, o_instr=32'h0000_0013 (NOP), o_instr_valid=0, o_mem_req=0, o_mem_addr=0, o_busy=0, o_fault=0, o_fault_cause=00, wait counter=0. Reset overrides all other inputs, including mid-transaction; a late ack after reset is ignored.
- States: IDLE, WAIT, FAULT.
- IDLE + i_fetch:
  - If o_pc[1:0]!=0: go to FAULT, cause 01, no request issued.
  - Otherwise: o_mem_addr<=o_pc, o_mem_req<=1, counter<=0, go to WAIT (o_busy=1 from next cycle).
- WAIT:
  - o_mem_req and o_mem_addr held stable until ack.
  - On i_mem_ack: o_instr<=i_mem_rdata, o_old_pc<=o_mem_addr, o_mem_req<=0, o_instr_valid=1 for exactly the next cycle, go to IDLE.
  - Without ack: counter increments; when counter==TIMEOUT-1 and no ack, go to FAULT, cause 10, o_mem_req<=0, o_instr unchanged.
  - Ack on the same cycle as the timeout threshold wins; no fault.
- Fetch latency: ack in cycle N gives o_instr and o_instr_valid in cycle N+1. Minimum fetch: i_fetch at cycle 0, req at cycle 1, ack at cycle 1, valid at cycle 2.
- i_mem_ack outside WAIT is ignored.
- i_fetch while WAIT or FAULT is dropped; no queuing.
- PC write:
  - i_pc_we loads o_pc<=i_pc_next in any non-reset state. Value is stored unchecked; misalignment is detected at the next fetch.
  - In-flight address is latched, so a PC write during WAIT does not alter o_mem_addr.
  - i_fetch and i_pc_we in the same IDLE cycle: the fetch uses the old o_pc, and o_pc takes i_pc_next.
- FAULT: o_fault=1, o_mem_req=0, o_busy=0. Held until i_fault_clr (next state IDLE, cause 00) or i_rst. i_fault_clr outside FAULT has no effect.
- Decode field outputs are pure combinational slices of o_instr.

Test Plan:
- Zero-wait fetch: o_pc=0, i_fetch, ack next cycle with rdata 32'h00500093 -> o_instr=32'h00500093, o_opcode=7'h13, o_rd=1, o_old_pc=0, valid pulse exactly 1 cycle.
- 3-wait fetch at o_pc=32'h40 -> o_mem_req high 4 cycles with addr stable at 32'h40, o_busy high, o_instr updates the cycle after ack.
- Timeout: TIMEOUT=15, no ack -> FAULT after 15 WAIT cycles, cause 10, req low, o_instr unchanged. i_fault_clr -> IDLE, cause 00.
- Misaligned: i_pc_we with 32'h42, then i_fetch -> no request, o_fault=1, cause 01.
- Simultaneous i_fetch + i_pc_we(32'h8) at o_pc=32'h4 -> o_mem_addr=32'h4, o_pc=32'h8. PC write 32'hC during WAIT -> o_mem_addr stays 32'h4.
- i_rst during WAIT, then late ack with 32'hFFFFFFFF -> all outputs at reset values, o_instr=NOP, no valid pulse. i_fetch during WAIT -> no second request.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: multicycle fetch stage feeding the main control FSM.
// Holds PC, OldPC and the instruction register. Issues word reads to unified
// memory over a req/ack handshake, with a wait timeout and a misalignment fault.
module instr_fetch_unit #(
  parameter int unsigned XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned TIMEOUT  = 15
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_fetch,
  input  logic            i_pc_we,
  input  logic [XLEN-1:0] i_pc_next,
  input  logic            i_fault_clr,
  output logic            o_mem_req,
  output logic [XLEN-1:0] o_mem_addr,
  input  logic            i_mem_ack,
  input  logic [31:0]     i_mem_rdata,
  output logic [31:0]     o_instr,
  output logic            o_instr_valid,
  output logic [6:0]      o_opcode,
  output logic [4:0]      o_rd,
  output logic [2:0]      o_funct3,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [6:0]      o_funct7,
  output logic [XLEN-1:0] o_pc,
  output logic [XLEN-1:0] o_old_pc,
  output logic            o_busy,
  output logic            o_fault,
  output logic [1:0]      o_fault_cause
);

  localparam logic [31:0] NOP_INSTR     = 32'h0000_0013;
  localparam logic [7:0]  WAIT_LAST     = 8'(TIMEOUT - 1);
  localparam logic [1:0]  CAUSE_NONE    = 2'b00;
  localparam logic [1:0]  CAUSE_MISALGN = 2'b01;
  localparam logic [1:0]  CAUSE_TIMEOUT = 2'b10;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t     state;
  logic [7:0] wait_cnt;

  // Fetch FSM: PC/IR bookkeeping, the memory handshake and the sticky fault, all registered
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state         <= IDLE;
      wait_cnt      <= '0;
      o_pc          <= RESET_PC;
      o_old_pc      <= RESET_PC;
      o_instr       <= NOP_INSTR;
      o_instr_valid <= 1'b0;
      o_mem_req     <= 1'b0;
      o_mem_addr    <= '0;
      o_busy        <= 1'b0;
      o_fault       <= 1'b0;
      o_fault_cause <= CAUSE_NONE;
    end else begin
      o_instr_valid <= 1'b0;

      if (i_pc_we) begin
        o_pc <= i_pc_next;
      end

      case (state)
        IDLE: begin
          if (i_fetch) begin
            if (o_pc[1:0] != 2'b00) begin
              state         <= FAULT;
              o_fault       <= 1'b1;
              o_fault_cause <= CAUSE_MISALGN;
            end else begin
              state      <= WAIT;
              o_mem_addr <= o_pc;
              o_mem_req  <= 1'b1;
              o_busy     <= 1'b1;
              wait_cnt   <= '0;
            end
          end
        end

        WAIT: begin
          if (i_mem_ack) begin
            state         <= IDLE;
            o_instr       <= i_mem_rdata;
            o_old_pc      <= o_mem_addr;
            o_instr_valid <= 1'b1;
            o_mem_req     <= 1'b0;
            o_busy        <= 1'b0;
          end else if (wait_cnt == WAIT_LAST) begin
            state         <= FAULT;
            o_mem_req     <= 1'b0;
            o_busy        <= 1'b0;
            o_fault       <= 1'b1;
            o_fault_cause <= CAUSE_TIMEOUT;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end

        FAULT: begin
          if (i_fault_clr) begin
            state         <= IDLE;
            o_fault       <= 1'b0;
            o_fault_cause <= CAUSE_NONE;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Decode fields are plain slices of the instruction register
  always_comb begin
    o_opcode = o_instr[6:0];
    o_rd     = o_instr[11:7];
    o_funct3 = o_instr[14:12];
    o_rs1    = o_instr[19:15];
    o_rs2    = o_instr[24:20];
    o_funct7 = o_instr[31:25];
  end

endmodule
